// File: rtl/ariane_ace.sv
// ACE snoop channel bundles (AC/CR/CD) as seen from the initiator side.
package ariane_ace;

  typedef struct packed {
    logic [63:0]          addr;
    snoop_pkg::acsnoop_t  snoop;
    logic [2:0]           prot;
  } ac_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } cd_chan_t;

  typedef struct packed {
    logic     ac_valid;
    ac_chan_t ac;
    logic     cr_ready;
    logic     cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic               ac_ready;
    logic               cr_valid;
    snoop_pkg::crresp_t cr_resp;
    logic               cd_valid;
    cd_chan_t           cd;
  } snoop_resp_t;

endpackage

// File: rtl/snoop_pkg.sv
// Shared snoop-channel types: ACE snoop opcodes, CR response flags, the initiator FSM states
// and a helper that line-aligns a byte address.
package snoop_pkg;

  typedef enum logic [3:0] {
    ReadOnce           = 4'b0000,
    ReadShared         = 4'b0001,
    ReadClean          = 4'b0010,
    ReadNotSharedDirty = 4'b0011,
    ReadUnique         = 4'b0111,
    CleanShared        = 4'b1000,
    CleanInvalid       = 4'b1001,
    MakeInvalid        = 4'b1101,
    DvmComplete        = 4'b1110,
    DvmMessage         = 4'b1111
  } acsnoop_t;

  typedef struct packed {
    logic wasUnique;
    logic isShared;
    logic passDirty;
    logic error;
    logic dataTransfer;
  } crresp_t;

  typedef enum logic [2:0] {
    IDLE,
    SEND_AC,
    WAIT_CR,
    RECV_CD,
    RESP
  } snoop_init_state_t;

  // lineBytes must be a power of two; the low address bits inside the line are dropped
  function automatic logic [63:0] lineAlign(input logic [63:0] addr, input int unsigned lineBytes);
    logic [63:0] mask;
    mask = 64'(lineBytes) - 64'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/snoop_cd_collector.sv
// Assembles CD beats into one cache line and flags early or missing 'last' beats.
// Once the final slot is filled, further beats are swallowed until 'last' arrives.
module snoop_cd_collector #(
  parameter int unsigned LineWidth = 128,
  parameter int unsigned DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 i_clear,
  input  logic                 i_beatValid,
  input  logic [DataWidth-1:0] i_beatData,
  input  logic                 i_beatLast,
  output logic [LineWidth-1:0] o_line,
  output logic                 o_done,
  output logic                 o_err
);

  localparam int unsigned Beats = LineWidth / DataWidth;
  localparam int unsigned CntW  = $clog2(Beats);
  localparam logic [CntW-1:0] LastIdx = CntW'(Beats - 1);

  logic [CntW-1:0]      r_cnt;
  logic                 r_full;
  logic                 r_err;
  logic [LineWidth-1:0] r_line;
  logic                 w_early;
  logic                 w_missing;

  assign w_early   = i_beatLast && (r_cnt != LastIdx);
  assign w_missing = !i_beatLast && (r_cnt == LastIdx) && !r_full;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_full <= 1'b0;
      r_err  <= 1'b0;
      r_line <= '0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_full <= 1'b0;
      r_err  <= 1'b0;
      r_line <= '0;
    end else if (i_beatValid) begin
      for (int b = 0; b < Beats; b++) begin
        if (!r_full && (r_cnt == CntW'(b))) begin
          r_line[b*DataWidth +: DataWidth] <= i_beatData;
        end
      end
      if (r_cnt == LastIdx) begin
        r_full <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_early || w_missing) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_line = r_line;
  assign o_done = i_beatValid && i_beatLast;
  assign o_err  = r_err;

endmodule

// File: rtl/snoop_initiator.sv
// Initiator side of the ACE snoop channels: one snoop in flight, AC out, CR/CD in, one line result back.
// Optional response watchdog enabled by defining SNOOP_INITIATOR_TIMEOUT_EN.
module snoop_initiator
  import snoop_pkg::*;
#(
  parameter int unsigned LineWidth     = 128,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [63:0]             req_addr_i,
  input  acsnoop_t                req_snoop_i,
  output logic                    resp_valid_o,
  input  logic                    resp_ready_i,
  output logic [LineWidth-1:0]    resp_data_o,
  output logic                    resp_has_data_o,
  output logic                    resp_pass_dirty_o,
  output logic                    resp_is_shared_o,
  output logic                    resp_error_o,
  output ariane_ace::snoop_req_t  snoop_req_o,
  input  ariane_ace::snoop_resp_t snoop_resp_i,
  output logic                    busy_o
);

  localparam int unsigned LineBytes = LineWidth / 8;

  snoop_init_state_t r_state;
  snoop_init_state_t w_nextState;

  logic [63:0] r_lineAddr;
  acsnoop_t    r_snoop;
  logic        r_hasData;
  logic        r_passDirty;
  logic        r_isShared;
  logic        r_crErr;

  logic w_accept;
  logic w_acHs;
  logic w_crHs;
  logic w_cdHs;
  logic w_cdDone;
  logic w_cdErr;
  logic w_timeout;
  logic w_toErr;
  logic w_unusedWasUnique;

  assign w_accept = (r_state == IDLE)    && req_valid_i;
  assign w_acHs   = (r_state == SEND_AC) && snoop_resp_i.ac_ready;
  assign w_crHs   = (r_state == WAIT_CR) && snoop_resp_i.cr_valid;
  assign w_cdHs   = (r_state == RECV_CD) && snoop_resp_i.cd_valid;

  assign w_unusedWasUnique = snoop_resp_i.cr_resp.wasUnique;

  snoop_cd_collector #(
    .LineWidth (LineWidth),
    .DataWidth (DataWidth)
  ) u_cdCollector (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .i_clear     (w_accept),
    .i_beatValid (w_cdHs),
    .i_beatData  (snoop_resp_i.cd.data[DataWidth-1:0]),
    .i_beatLast  (snoop_resp_i.cd.last),
    .o_line      (resp_data_o),
    .o_done      (w_cdDone),
    .o_err       (w_cdErr)
  );

`ifdef SNOOP_INITIATOR_TIMEOUT_EN
  localparam int unsigned ToWidth = $clog2(TimeoutCycles + 1);
  localparam logic [ToWidth-1:0] ToLast = ToWidth'(TimeoutCycles - 1);

  logic [ToWidth-1:0] r_toCnt;
  logic               r_toErr;
  logic               w_waiting;

  assign w_waiting = (r_state == WAIT_CR) || (r_state == RECV_CD);
  assign w_timeout = w_waiting && !w_crHs && !w_cdHs && (r_toCnt == ToLast);

  // Watchdog restarts on every channel handshake, so it measures idle gaps, not total latency
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_toCnt <= '0;
      r_toErr <= 1'b0;
    end else begin
      if (w_acHs || w_crHs || w_cdHs) begin
        r_toCnt <= '0;
      end else if (w_waiting) begin
        r_toCnt <= r_toCnt + 1'b1;
      end
      if (w_accept) begin
        r_toErr <= 1'b0;
      end else if (w_timeout) begin
        r_toErr <= 1'b1;
      end
    end
  end

  assign w_toErr = r_toErr;
`else
  logic w_unusedTimeout;
  assign w_unusedTimeout = ^TimeoutCycles;
  assign w_timeout       = 1'b0;
  assign w_toErr         = 1'b0;
`endif

  always_comb begin
    w_nextState  = r_state;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    snoop_req_o          = '0;
    snoop_req_o.ac.addr  = r_lineAddr;
    snoop_req_o.ac.snoop = r_snoop;
    snoop_req_o.ac.prot  = 3'b000;
    unique case (r_state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) w_nextState = SEND_AC;
      end
      SEND_AC: begin
        snoop_req_o.ac_valid = 1'b1;
        if (snoop_resp_i.ac_ready) w_nextState = WAIT_CR;
      end
      WAIT_CR: begin
        snoop_req_o.cr_ready = 1'b1;
        if (snoop_resp_i.cr_valid) begin
          w_nextState = snoop_resp_i.cr_resp.dataTransfer ? RECV_CD : RESP;
        end else if (w_timeout) begin
          w_nextState = RESP;
        end
      end
      RECV_CD: begin
        snoop_req_o.cd_ready = 1'b1;
        if (w_cdDone || w_timeout) w_nextState = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= IDLE;
      r_lineAddr  <= '0;
      r_snoop     <= ReadOnce;
      r_hasData   <= 1'b0;
      r_passDirty <= 1'b0;
      r_isShared  <= 1'b0;
      r_crErr     <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_lineAddr  <= lineAlign(req_addr_i, LineBytes);
        r_snoop     <= req_snoop_i;
        r_hasData   <= 1'b0;
        r_passDirty <= 1'b0;
        r_isShared  <= 1'b0;
        r_crErr     <= 1'b0;
      end
      if (w_crHs) begin
        r_hasData   <= snoop_resp_i.cr_resp.dataTransfer;
        r_passDirty <= snoop_resp_i.cr_resp.passDirty;
        r_isShared  <= snoop_resp_i.cr_resp.isShared;
        r_crErr     <= snoop_resp_i.cr_resp.error;
      end
    end
  end

  assign resp_has_data_o   = r_hasData;
  assign resp_pass_dirty_o = r_passDirty;
  assign resp_is_shared_o  = r_isShared;
  assign resp_error_o      = r_crErr || w_cdErr || w_toErr;
  assign busy_o            = (r_state != IDLE);

endmodule

// File: doc/snoop_initiator.md
Name: snoop_initiator

Overview:
- Initiator end of the ACE snoop channel set (AC/CR/CD). It is the block an interconnect/CCU port uses to snoop one cache.
- Accepts one snoop command from a requester and drives the AC channel. It then collects the CR response and, if data is transferred, the CD beats of a full cache line.
- It returns one assembled result (line data plus response flags) to the requester.
- Strictly one outstanding snoop; sits between the CCU snoop arbiter and a core's snoop responder port.

Parameters:
- LineWidth, 128, cache line width in bits.
- DataWidth, 64, CD beat width in bits. Beats = LineWidth/DataWidth, which must be at least 2.
- TimeoutCycles, 1024, response watchdog limit. Used only when SNOOP_INITIATOR_TIMEOUT_EN is defined.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  snoop command valid
- req_ready_o  out  1  command accepted
- req_addr_i  in  64  snoop address, any byte alignment
- req_snoop_i  in  $bits(snoop_pkg::acsnoop_t)  snoop type
- resp_valid_o  out  1  result valid
- resp_ready_i  in  1  result consumed
- resp_data_o  out  LineWidth  assembled line; zero if no data was transferred
- resp_has_data_o  out  1  CR.dataTransfer was set
- resp_pass_dirty_o  out  1  CR.passDirty
- resp_is_shared_o  out  1  CR.isShared
- resp_error_o  out  1  CR.error, protocol error, or timeout
- snoop_req_o  out  ariane_ace::snoop_req_t  ac_valid, ac, cr_ready, cd_ready
- snoop_resp_i  in  ariane_ace::snoop_resp_t  ac_ready, cr_valid, cr_resp, cd_valid, cd
- busy_o  out  1  state != IDLE

Behaviour:
- Reset is rst_ni, asynchronous, active-low; clock is clk_i. Reset forces state IDLE and clears all registers.
  - Out of reset all outputs are 0, except req_ready_o = 1.
  - Reset mid-operation abandons the transaction; no partial response is issued.
- States: IDLE, SEND_AC, WAIT_CR, RECV_CD, RESP.
- IDLE:
  - req_ready_o = 1; ac_valid, cr_ready and cd_ready are 0.
  - On req_valid_i: latch the line-aligned address {req_addr_i[63:log2(LineWidth/8)], zeros} and the snoop type.
  - Clear the line buffer, flags and beat counter, then go to SEND_AC.
- SEND_AC:
  - ac_valid = 1; ac.addr and ac.snoop come from the latched values and stay stable until handshake; ac.prot = 0.
  - On ac_ready go to WAIT_CR.
  - AC is issued the cycle after acceptance (1-cycle latency).
- WAIT_CR:
  - cr_ready = 1. On cr_valid latch dataTransfer, passDirty, isShared and error.
  - If dataTransfer = 1 go to RECV_CD; otherwise go to RESP.
  - dataTransfer = 1 with error = 1 still collects data and reports error.
- RECV_CD:
  - cd_ready = 1. Each beat is written to buffer bits [cnt*DataWidth +: DataWidth]; cnt increments and saturates at Beats-1.
  - Exit to RESP on the beat with cd.last = 1.
  - Early last (cnt < Beats-1): set error; unreceived beats stay zero.
  - Missing last at cnt = Beats-1: set error, keep accepting and discarding beats until last.
- RESP:
  - resp_valid_o = 1 with all resp_* outputs held stable.
  - On resp_ready_i go to IDLE. A new request is accepted no earlier than the following cycle.
- No same-cycle bypass: CR and CD are never accepted before the AC handshake completes.
- CR and CD arriving in the same cycle: CD is not accepted until the state is RECV_CD.
- Best case, no data: request accepted at cycle 0, AC at cycle 1, CR at cycle 2, resp_valid at cycle 3.

Optional Feature:
- Macro SNOOP_INITIATOR_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TimeoutCycles+1) clears on entry to WAIT_CR and increments each cycle in WAIT_CR and RECV_CD.
  - It resets on every CR or CD handshake.
  - Reaching TimeoutCycles forces RESP with resp_error_o = 1 and the flags received so far.
  - Late CR/CD traffic after a timeout is not tracked and is treated as system-fatal.
- Undefined: no counter; the block waits indefinitely and the TimeoutCycles parameter is unused.

Decomposition:
- snoop_pkg gets snoop_init_state_t (the 5-state enum) and a helper function for line-aligning an address.
- It reuses the existing acsnoop_t and crresp_t; the ace types come from ariane_ace.
- One natural sub-module: snoop_cd_collector. It holds the beat counter, line buffer and last/early/missing checks, with a clear input and a done/err output.

Test Plan:
- READ_SHARED to addr 0x8000_1234, CR {dataTransfer=1, isShared=1}, CD beats 0xAAAA..., then 0xBBBB... with last=1 -> ac.addr 0x8000_1230; resp_data = {0xBBBB...,0xAAAA...}; has_data=1, is_shared=1, error=0.
- CLEAN_INVALID, CR all zeros -> resp_valid 3 cycles after acceptance; resp_data=0, has_data=0, error=0; no cd_ready is asserted.
- ac_ready held low 5 cycles, resp_ready low 4 cycles -> ac fields stable throughout; resp fields stable; req_ready_o low until the cycle after the resp handshake.
- CD with last=1 on beat 0 -> error=1, upper 64 bits zero. Separately, 3 beats with last only on beat 2 -> error=1, third beat discarded.
- Reset asserted in RECV_CD after 1 beat -> all outputs 0 and req_ready_o=1 immediately; the next transaction completes normally.
- With SNOOP_INITIATOR_TIMEOUT_EN and TimeoutCycles=16, cr_valid never asserted -> resp_valid with error=1 exactly 16 cycles after entering WAIT_CR.
